// File: rtl/xor_share_arb.sv
// xor_share_arb: round-robin arbiter that shares one XOR datapath among
// NREQ requesters. Each requester has its own enable bit in DOIT_MASK;
// disabled requesters receive an all-zero result. The result is held in a
// single-entry registered output stage with a valid/ready handshake.
module xor_share_arb #(
    parameter int                NREQ      = 2,
    parameter int                WIDTH     = 1,
    parameter logic [NREQ-1:0]   DOIT_MASK = {NREQ{1'b1}},
    localparam int               IDW       = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_data
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [IDW-1:0]       id_q, id_d;

    logic                 win_found_s;
    logic [IDW-1:0]       win_id_s;
    logic                 can_accept_s;
    logic                 grant_s;
    logic [WIDTH-1:0]     win_a_s;
    logic [WIDTH-1:0]     win_b_s;

    // Shared datapath: XOR when the requester is enabled, zero otherwise.
    function automatic logic [WIDTH-1:0] share_xor(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             en
    );
        if (en) begin
            return a ^ b;
        end else begin
            return {WIDTH{1'b0}};
        end
    endfunction

    // Round-robin search: first valid requester starting at ptr, wrapping
    // modulo NREQ (NREQ need not be a power of two).
    always_comb begin
        logic [IDW:0] cand;
        win_found_s = 1'b0;
        win_id_s    = {IDW{1'b0}};
        cand        = {(IDW+1){1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end else begin
                cand = cand;
            end
            if (!win_found_s && req_valid[cand[IDW-1:0]]) begin
                win_found_s = 1'b1;
                win_id_s    = cand[IDW-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Slot is free when empty or when the held result leaves this cycle;
    // grants are suppressed while reset is asserted.
    always_comb begin
        can_accept_s = (state_q == ST_EMPTY) || rsp_ready;
        grant_s      = win_found_s && can_accept_s && !rst;
    end

    // One-hot ready toward the winning requester only.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (grant_s) begin
            req_ready[win_id_s] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Operand mux for the winner; only feeds the result register, never ready.
    always_comb begin
        win_a_s = req_a[win_id_s*WIDTH +: WIDTH];
        win_b_s = req_b[win_id_s*WIDTH +: WIDTH];
    end

    // Next-state logic for the output stage and round-robin pointer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        if (grant_s) begin
            state_d = ST_FULL;
            data_d  = share_xor(win_a_s, win_b_s, DOIT_MASK[win_id_s]);
            id_d    = win_id_s;
            if (win_id_s == IDW'(NREQ - 1)) begin
                ptr_d = {IDW{1'b0}};
            end else begin
                ptr_d = win_id_s + IDW'(1);
            end
        end else begin
            case (state_q)
                ST_FULL: begin
                    if (rsp_ready) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                ST_EMPTY: state_d = ST_EMPTY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ptr_q   <= {IDW{1'b0}};
            data_q  <= {WIDTH{1'b0}};
            id_q    <= {IDW{1'b0}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    // Response outputs come straight from flops.
    always_comb begin
        rsp_valid = (state_q == ST_FULL);
        rsp_data  = data_q;
        rsp_id    = id_q;
    end

endmodule
